// File: rtl/axi_st_wr_ctrl_pkg.sv
// Shared parameter defaults, legal ranges and the elaboration-time range check
// for the FIFO-to-AXI-Stream write controller.
package axi_st_wr_ctrl_pkg;

  localparam int DWIDTH_DEF     = 64;
  localparam int DWIDTH_MIN     = 8;
  localparam int DWIDTH_MAX     = 1024;
  localparam int RD_LAT_DEF     = 1;
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 4;
  localparam int OBUF_DEPTH_DEF = 4;
  localparam int OBUF_DEPTH_MIN = 2;
  localparam int OBUF_DEPTH_MAX = 16;

  function automatic bit params_ok(input int dwidth, input int rd_lat, input int depth);
    return (dwidth >= DWIDTH_MIN) && (dwidth <= DWIDTH_MAX) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) &&
           (depth >= OBUF_DEPTH_MIN) && (depth <= OBUF_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/axi_st_obuf.sv
// Circular output buffer: register array with wrapping head/tail pointers and
// a registered non-empty flag so valid/data leave the block straight from flops.
module axi_st_obuf
  import axi_st_wr_ctrl_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = OBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              not_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign count_next = count + CW'(push) - CW'(pop);
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_next;
      not_empty <= (count_next != '0);
    end
  end

endmodule

// File: rtl/axi_st_wr_ctrl_pipe.sv
// Reads a latency-RD_LAT source FIFO into an AXI-Stream master, using an
// occupancy credit so every in-flight read is guaranteed a buffer slot.
module axi_st_wr_ctrl_pipe
  import axi_st_wr_ctrl_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              axist_valid,
  input  logic              axist_rdy,
  output logic [DWIDTH-1:0] axist_data,
  output logic [31:0]       xfer_cnt
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);

  if (!params_ok(DWIDTH, RD_LAT, OBUF_DEPTH)) begin : g_bad_params
    $error("axi_st_wr_ctrl_pipe: DWIDTH/RD_LAT/OBUF_DEPTH out of range (OBUF_DEPTH must be >= 2)");
  end

  logic [RD_LAT-1:0] inflight;
  logic [CW-1:0]     occ;
  logic              push;
  logic              pop;

  assign push = inflight[RD_LAT-1];
  assign pop  = axist_valid & axist_rdy;

  // occ counts in-flight reads too, so a read is only issued when its slot is reserved.
  assign fifo_rden = rst_n & enable & ~fifo_empty & (occ < CW'(OBUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      occ      <= '0;
      xfer_cnt <= '0;
    end else begin
      inflight <= (inflight << 1) | RD_LAT'(fifo_rden);
      occ      <= occ + CW'(fifo_rden) - CW'(pop);
      xfer_cnt <= xfer_cnt + 32'(pop);
    end
  end

  axi_st_obuf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (axist_data),
    .not_empty (axist_valid)
  );

endmodule

// File: tb/tb_axi_st_wr_ctrl_pipe.sv
// Bench for axi_st_wr_ctrl_pipe: FIFO model with read latency, ordered
// scoreboard, directed scenario table and a randomized ready/enable run.
module tb_axi_st_wr_ctrl_pipe;

  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rden;
  logic [DW-1:0] fifo_rdata;
  logic          axist_valid;
  logic          axist_rdy;
  logic [DW-1:0] axist_data;
  logic [31:0]   xfer_cnt;

  always #5 clk = ~clk;

  axi_st_wr_ctrl_pipe #(
    .DWIDTH     (DW),
    .RD_LAT     (RL),
    .OBUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_rdata  (fifo_rdata),
    .axist_valid (axist_valid),
    .axist_rdy   (axist_rdy),
    .axist_data  (axist_data),
    .xfer_cnt    (xfer_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Source FIFO model: words read on an rden edge appear RL cycles later.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pipe [RL];

  always @(posedge clk) begin
    logic [DW-1:0] w;
    w = 32'hDEAD_BEEF;
    if (fifo_rden) begin
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
      end else begin
        failures++;
        $display("FAIL fifo_underflow actual=rden_on_empty expected=no_rden");
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
    pipe[0] <= w;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign fifo_rdata = pipe[RL-1];

  // Monitor on the falling edge: order, hold-stability and occupancy bound.
  int          cyc = 0;
  int          rden_cnt, beat_cnt, occ_m, first_rden, first_valid, valid_cycles;
  logic        hold_prev;
  logic [31:0] prev_data;
  logic [31:0] first_beat;
  bit          got_first;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rden_cnt = 0; beat_cnt = 0; occ_m = 0; valid_cycles = 0;
      first_rden = -1; first_valid = -1;
      hold_prev = 1'b0; got_first = 1'b0; first_beat = '0;
      exp_q.delete();
    end else begin
      if (fifo_rden) begin
        rden_cnt++;
        if (first_rden < 0) first_rden = cyc;
      end
      if (axist_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (hold_prev) begin
        chk("hold_valid", 64'(axist_valid), 64'd1);
        chk("hold_data", 64'(axist_data), 64'(prev_data));
      end
      if (axist_valid && axist_rdy) begin
        if (!got_first) begin
          got_first  = 1'b1;
          first_beat = axist_data;
        end
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_extra actual=0x%0h expected=no_beat", axist_data);
        end else begin
          chk("beat_data", 64'(axist_data), 64'(exp_q.pop_front()));
        end
        beat_cnt++;
      end
      occ_m = occ_m + int'(fifo_rden) - int'(axist_valid && axist_rdy);
      if (occ_m > DEPTH || occ_m < 0) begin
        checks++; failures++;
        $display("FAIL occ_bound actual=%0d expected=0..%0d", occ_m, DEPTH);
      end
      hold_prev = axist_valid & ~axist_rdy;
      prev_data = axist_data;
    end
  end

  int en_limit = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (en_limit > 0 && rden_cnt >= en_limit) enable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; axist_rdy = 1'b0; en_limit = 0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    int          n_words;
    logic [31:0] base;
    int          rdy_hold;
    int          en_reads;
    int          exp_rden_hold;
    int          exp_rden;
    int          exp_beats;
    int          exp_valid_cycles;
    logic        exp_empty_end;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] head;
    int          rem;
    int          guard;

    vecs[0] = '{"stream8",   8, 32'h1,  0, 0, 0, 8, 8,  8, 1'b1};
    vecs[1] = '{"stall8",    8, 32'h1, 20, 0, 4, 8, 8, -1, 1'b1};
    vecs[2] = '{"single",    1, 32'hA5, 0, 0, 0, 1, 1,  1, 1'b1};
    vecs[3] = '{"en_off",    6, 32'h10, 0, 2, 0, 2, 2,  2, 1'b0};

    // Reset state, with enable high and a non-empty FIFO flag.
    rst_n = 1'b0; enable = 1'b1; fifo_empty = 1'b0; axist_rdy = 1'b1;
    #2;
    chk("rst_rden",  64'(fifo_rden),   64'd0);
    chk("rst_valid", 64'(axist_valid), 64'd0);
    chk("rst_data",  64'(axist_data),  64'd0);
    chk("rst_xfer",  64'(xfer_cnt),    64'd0);

    foreach (vecs[k]) begin
      do_reset();
      for (int i = 0; i < vecs[k].n_words; i++) fifo_q.push_back(vecs[k].base + 32'(i));
      fifo_empty = 1'b0;
      en_limit   = vecs[k].en_reads;
      enable     = 1'b1;
      axist_rdy  = (vecs[k].rdy_hold == 0);
      repeat (vecs[k].rdy_hold) step();
      if (vecs[k].rdy_hold > 0) begin
        chk({vecs[k].name, "_hold_rden"},  64'(rden_cnt),    64'(vecs[k].exp_rden_hold));
        chk({vecs[k].name, "_hold_valid"}, 64'(axist_valid), 64'd1);
        chk({vecs[k].name, "_hold_data"},  64'(axist_data),  64'(vecs[k].base));
      end
      axist_rdy = 1'b1;
      repeat (40) step();
      chk({vecs[k].name, "_latency"}, 64'(first_valid - first_rden), 64'(RL + 1));
      chk({vecs[k].name, "_rden"},    64'(rden_cnt),    64'(vecs[k].exp_rden));
      chk({vecs[k].name, "_beats"},   64'(beat_cnt),    64'(vecs[k].exp_beats));
      chk({vecs[k].name, "_xfer"},    64'(xfer_cnt),    64'(vecs[k].exp_beats));
      chk({vecs[k].name, "_drained"}, 64'(axist_valid), 64'd0);
      chk({vecs[k].name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      chk({vecs[k].name, "_first"},   64'(first_beat),  64'(vecs[k].base));
      chk({vecs[k].name, "_fifo_empty"}, 64'(fifo_empty), 64'(vecs[k].exp_empty_end));
      if (vecs[k].exp_valid_cycles >= 0)
        chk({vecs[k].name, "_valid_cycles"}, 64'(valid_cycles), 64'(vecs[k].exp_valid_cycles));
    end

    // Reset mid-stream: outputs clear without a clock edge, stream restarts at FIFO head.
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h100 + 32'(i));
    fifo_empty = 1'b0;
    enable     = 1'b1;
    repeat (8) step();
    chk("mid_pre_valid", 64'(axist_valid), 64'd1);
    axist_rdy = 1'b1;
    repeat (2) step();
    chk("mid_pre_xfer", 64'(xfer_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(axist_valid), 64'd0);
    chk("mid_rst_rden",  64'(fifo_rden),   64'd0);
    chk("mid_rst_xfer",  64'(xfer_cnt),    64'd0);
    head = fifo_q[0];
    rem  = fifo_q.size();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (25) step();
    chk("mid_restart_head", 64'(first_beat), 64'(head));
    chk("mid_restart_beats", 64'(beat_cnt), 64'(rem));
    chk("mid_restart_xfer",  64'(xfer_cnt), 64'(rem));

    // Randomized ready (50%) and mostly-on enable over 1000 words.
    do_reset();
    for (int i = 0; i < 1000; i++) fifo_q.push_back($urandom);
    fifo_empty = 1'b0;
    guard = 0;
    while (beat_cnt < 1000 && guard < 8000) begin
      axist_rdy = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 9) != 0);
      step();
      guard++;
    end
    axist_rdy = 1'b0;
    enable    = 1'b0;
    step();
    chk("rand_beats",    64'(beat_cnt),     64'd1000);
    chk("rand_xfer",     64'(xfer_cnt),     64'd1000);
    chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_fifo_empty", 64'(fifo_empty), 64'd1);
    chk("rand_valid_end", 64'(axist_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_st_wr_ctrl_pipe.md
AXI_ST_WR_CTRL_PIPE -- requirements
Module: axi_st_wr_ctrl_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 64: data width in bits, range 8..1024.
REQ-002 SHALL have parameter RD_LAT, default 1: FIFO read latency in clocks (fifo_rden to fifo_rdata valid), range 1..4.
REQ-003 SHALL have parameter OBUF_DEPTH, default 4: output buffer entries, range 2..16.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1: permits new FIFO reads.
REQ-007 SHALL have port fifo_empty, input, 1: source FIFO empty.
REQ-008 SHALL have port fifo_rden, output, 1: FIFO read strobe.
REQ-009 SHALL have port fifo_rdata, input, DWIDTH: FIFO read data.
REQ-010 SHALL have port axist_valid, output, 1: AXI-ST valid.
REQ-011 SHALL have port axist_rdy, input, 1: AXI-ST ready.
REQ-012 SHALL have port axist_data, output, DWIDTH: AXI-ST data.
REQ-013 SHALL have port xfer_cnt, output, 32: completed beats, wrapping modulo 2^32.

Function
REQ-014 SHALL track in-flight reads with an RD_LAT-stage shift register; a 1 enters when fifo_rden=1.
REQ-015 SHALL write fifo_rdata into the output buffer on the clock edge ending the cycle where the shift-register tail is 1 (RD_LAT cycles after the rden cycle).
REQ-016 SHALL keep a registered occupancy count occ = in-flight + buffered entries, width clog2(OBUF_DEPTH+1).
REQ-017 SHALL drive fifo_rden = enable & ~fifo_empty & (occ < OBUF_DEPTH), with no combinational path from axist_rdy.
REQ-018 SHALL never overflow the buffer: the credit rule in REQ-017 guarantees a free slot for every in-flight read.
REQ-019 SHALL drive axist_valid = buffer not empty and axist_data = buffer head, both from registers.
REQ-020 SHALL complete a beat when axist_valid & axist_rdy; head pointer advances, occ decrements, xfer_cnt increments.
REQ-021 SHALL hold axist_valid and axist_data stable while axist_valid=1 and axist_rdy=0.
REQ-022 SHALL handle a same-cycle read issue and beat completion so that occ is unchanged; same-cycle capture and pop SHALL both succeed.
REQ-023 SHALL use circular head/tail pointers wrapping at OBUF_DEPTH, including non-power-of-two depths.
REQ-024 SHALL have an empty-to-first-valid latency of RD_LAT+1 cycles after fifo_rden assertion.
REQ-025 SHALL sustain one beat per cycle with axist_rdy=1 when OBUF_DEPTH >= RD_LAT+2.
REQ-026 SHALL, on enable deassertion, stop new reads immediately while in-flight and buffered data still drain.
REQ-027 SHALL preserve FIFO order, with no loss or duplication under any axist_rdy pattern.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force fifo_rden=0, axist_valid=0, axist_data=0, xfer_cnt=0, occ=0, pointers=0 and the shift register=0.
REQ-029 SHALL discard in-flight and buffered data on reset mid-operation; reads resume one cycle after rst_n rises.

Structure
REQ-030 SHALL take parameter defaults and range limits from package axi_st_wr_ctrl_pkg, which SHALL include an elaboration check that OBUF_DEPTH >= 2.
REQ-031 SHALL implement the buffer as sub-module axi_st_obuf (circular register array, DWIDTH x OBUF_DEPTH, push/pop/count).

Verification
Bench parameters: DWIDTH=32, RD_LAT=2, OBUF_DEPTH=4.
REQ-032 SHALL cover: FIFO preloaded 0x1..0x8, rdy=1 -> first valid 3 cycles after first rden; 8 consecutive beats 0x1..0x8; xfer_cnt=8.
REQ-033 SHALL cover: 8 words, rdy=0 -> exactly 4 rden pulses; valid=1 and data=0x1 held; rdy=1 -> remaining words in order, none lost.
REQ-034 SHALL cover: single word 0xA5 into an empty FIFO -> one rden, valid for exactly one beat with rdy=1, then valid=0.
REQ-035 SHALL cover: enable=0 after 2 reads of a 6-word FIFO -> no further rden; 2 beats delivered; fifo_empty stays 0.
REQ-036 SHALL cover: rst_n=0 mid-stream with valid=1 -> valid, rden and xfer_cnt go to 0 without a clock edge; after release, a fresh stream starts at the current FIFO head.
REQ-037 SHALL cover: random rdy at 50% with 1000 words -> scoreboard order match, no overflow, occ <= 4 always.
